// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one memory request per PC, holds the
// returned word for decode, and recovers from flushes and hung memory.
module inst_fetch #(
  parameter logic [31:0] RESET_INST = 32'h0000_0000,
  parameter int          MAX_WAIT   = 255,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        pc_hold,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FULL,
    DROP
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      inst_d, inst_pc_d;
  logic             at_last;

  assign at_last    = (cnt == LAST);
  assign mem_req    = (state == WAIT);
  assign mem_addr   = addr_q;
  assign inst_valid = (state == FULL);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      inst    <= RESET_INST;
      inst_pc <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      inst    <= inst_d;
      inst_pc <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_q;
    inst_d    = inst;
    inst_pc_d = inst_pc;
    pc_hold   = 1'b0;
    fetch_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_en && !flush) begin
          addr_d  = fetch_pc;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        pc_hold = 1'b1;
        if (flush) begin
          cnt_d   = '0;
          state_d = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          inst_d    = mem_rdata;
          inst_pc_d = addr_q;
          state_d   = FULL;
        end else if (at_last) begin
          fetch_err = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      FULL: begin
        pc_hold = !inst_ready;
        if (flush) begin
          state_d = IDLE;
        end else if (inst_ready && fetch_en) begin
          addr_d  = fetch_pc;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (inst_ready) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        // Waits out the abandoned request so its ack cannot be misread
        pc_hold = 1'b1;
        if (mem_ack || at_last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
